uart_tx_param: RTL

- Parametrised successor to the team's fixed 8N1 UART transmitter.
- Serialises one frame per accepted word: start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
- Valid/ready input handshake replaces the level-sensitive data-available strobe.
- Sits between a byte/word source (FIFO or CPU register) and the TX pin; bit timing comes from an external one-cycle baud tick.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_param_if.sv | 34 +++
 rtl/uart_tx_param.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM states, parity modes, parity helper.
// The BREAK/BRK_MARK states exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

   localparam int MAX_DATA_BITS = 9;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_STOP     = 3'd4
`ifdef UART_TX_BREAK_EN
      ,
      ST_BREAK    = 3'd5,
      ST_BRK_MARK = 3'd6
`endif
   } uart_state_e;

   // Callers zero-extend narrower words; the extra zeros leave the XOR unchanged.
   function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0] mode);
      logic x_s;
      logic p_s;
      x_s = ^data;
      case (mode)
         PAR_EVEN: p_s = x_s;
         PAR_ODD:  p_s = ~x_s;
         PAR_NONE: p_s = 1'b0;
         default:  p_s = 1'b0;
      endcase
      return p_s;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Source-side bus of the parametrised UART transmitter (handshake, word, tick, line status).
// i_break is present only when UART_TX_BREAK_EN is defined.
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_tick;
   logic                 i_valid;
   logic [DATA_BITS-1:0] i_data;
   logic [1:0]           i_parity_mode;
`ifdef UART_TX_BREAK_EN
   logic                 i_break;
`endif
   logic                 o_ready;
   logic                 o_tx;
   logic                 o_active;
   logic                 o_done;
   logic [3:0]           o_bit_idx;

   modport slave (
      input  i_tick, i_valid, i_data, i_parity_mode,
`ifdef UART_TX_BREAK_EN
      input  i_break,
`endif
      output o_ready, o_tx, o_active, o_done, o_bit_idx
   );

   modport master (
      output i_tick, i_valid, i_data, i_parity_mode,
`ifdef UART_TX_BREAK_EN
      output i_break,
`endif
      input  o_ready, o_tx, o_active, o_done, o_bit_idx
   );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Defining UART_TX_BREAK_EN adds a line-break generator driven by i_break.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter bit IDLE_LEVEL = 1'b1
)(
   input logic             clk,
   input logic             rst_n,
   uart_tx_param_if.slave  bus
);

   localparam logic [3:0] IDX_LAST  = 4'(DATA_BITS - 1);
   localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

   uart_state_e          state_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [3:0]           idx_r;
   logic [1:0]           stop_cnt_r;
   logic                 par_en_r;
   logic                 par_bit_r;
   logic                 ready_r;
   logic                 tx_r;
   logic                 active_r;
   logic                 done_r;

   assign bus.o_ready   = ready_r;
   assign bus.o_tx      = tx_r;
   assign bus.o_active  = active_r;
   assign bus.o_done    = done_r;
   assign bus.o_bit_idx = idx_r;

   // Frame FSM with shift register, stop counter and registered line outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         shift_r    <= '0;
         idx_r      <= 4'd0;
         stop_cnt_r <= 2'd0;
         par_en_r   <= 1'b0;
         par_bit_r  <= 1'b0;
         ready_r    <= 1'b0;
         tx_r       <= IDLE_LEVEL;
         active_r   <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
               if (bus.i_break) begin
                  state_r  <= ST_BREAK;
                  tx_r     <= ~IDLE_LEVEL;
                  ready_r  <= 1'b0;
                  active_r <= 1'b1;
               end else
`endif
               if (bus.i_valid && ready_r) begin
                  // Parity is resolved here so later i_data/i_parity_mode changes cannot leak in.
                  shift_r   <= bus.i_data;
                  par_en_r  <= (bus.i_parity_mode == PAR_EVEN) || (bus.i_parity_mode == PAR_ODD);
                  par_bit_r <= parity_calc(MAX_DATA_BITS'(bus.i_data), bus.i_parity_mode);
                  idx_r     <= 4'd0;
                  ready_r   <= 1'b0;
                  active_r  <= 1'b1;
                  tx_r      <= ~IDLE_LEVEL;
                  state_r   <= ST_START;
               end else begin
                  ready_r  <= 1'b1;
                  active_r <= 1'b0;
                  tx_r     <= IDLE_LEVEL;
               end
            end
            ST_START: begin
               if (bus.i_tick) begin
                  state_r <= ST_DATA;
                  idx_r   <= 4'd0;
                  tx_r    <= shift_r[0];
               end
            end
            ST_DATA: begin
               if (bus.i_tick) begin
                  if (idx_r == IDX_LAST) begin
                     if (par_en_r) begin
                        state_r <= ST_PARITY;
                        tx_r    <= par_bit_r;
                     end else begin
                        state_r    <= ST_STOP;
                        tx_r       <= IDLE_LEVEL;
                        stop_cnt_r <= 2'd0;
                     end
                  end else begin
                     idx_r   <= idx_r + 4'd1;
                     shift_r <= shift_r >> 1;
                     tx_r    <= shift_r[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bus.i_tick) begin
                  state_r    <= ST_STOP;
                  tx_r       <= IDLE_LEVEL;
                  stop_cnt_r <= 2'd0;
               end
            end
            ST_STOP: begin
               if (bus.i_tick) begin
                  if (stop_cnt_r == STOP_LAST) begin
                     state_r  <= ST_IDLE;
                     active_r <= 1'b0;
                     done_r   <= 1'b1;
                     ready_r  <= 1'b1;
                  end else begin
                     stop_cnt_r <= stop_cnt_r + 2'd1;
                  end
               end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
               if (!bus.i_break) begin
                  state_r    <= ST_BRK_MARK;
                  tx_r       <= IDLE_LEVEL;
                  stop_cnt_r <= 2'd0;
               end
            end
            ST_BRK_MARK: begin
               if (bus.i_tick) begin
                  if (stop_cnt_r == STOP_LAST) begin
                     state_r  <= ST_IDLE;
                     active_r <= 1'b0;
                     ready_r  <= 1'b1;
                  end else begin
                     stop_cnt_r <= stop_cnt_r + 2'd1;
                  end
               end
            end
`endif
            default: begin
               state_r  <= ST_IDLE;
               tx_r     <= IDLE_LEVEL;
               ready_r  <= 1'b0;
               active_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
